// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling
// ratios, default word width and the parity helper shared with the TX side.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Parity bit value for a data word: even parity (typ=0) makes the total
    // number of ones even, odd parity (typ=1) makes it odd.
    function automatic logic par_calc(input logic [UART_DATA_WIDTH-1:0] data,
                                      input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine for the receiver: counts clocks within a bit, takes three
// samples around the bit centre and produces a majority-voted bit value.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_s_i,
    input  logic                  start_i,
    input  logic                  active_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sample_done_o,
    output logic                  sample_bit_o,
    output logic                  bit_end_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [1:0]            taps;

    assign half      = {1'b0, prescale_i[PRESCALE_W-1:1]};
    assign last_edge = prescale_i - 1'b1;

    // Edge counter: the start-detect cycle is edge 0, so a detect loads 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (start_i) begin
            edge_cnt_d = PRESCALE_W'(1);
        end else if (active_i) begin
            edge_cnt_d = (edge_cnt_q == last_edge) ? '0 : edge_cnt_q + 1'b1;
        end else begin
            edge_cnt_d = '0;
        end
    end

    // Edge counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Early taps at P/2-2 and P/2-1; the third vote is the live sample at P/2.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tap
            localparam logic [PRESCALE_W-1:0] OFFS = PRESCALE_W'(2 - gi);
            logic tap_q;

            // Capture the line at this tap's edge position.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    tap_q <= 1'b1;
                end else if (active_i && (edge_cnt_q == half - OFFS)) begin
                    tap_q <= rx_s_i;
                end
            end

            assign taps[gi] = tap_q;
        end
    endgenerate

    assign sample_done_o = active_i && (edge_cnt_q == half);
    assign sample_bit_o  = (taps[0] & taps[1]) | (taps[0] & rx_s_i) | (taps[1] & rx_s_i);
    assign bit_end_o     = active_i && (edge_cnt_q == last_edge);

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchronizer, frame FSM, deserializer, parity and
// stop checks, and registered output pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic                  rx_meta_q, rx_s_q;
    rx_state_e             state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_bad_q, par_bad_d;
    logic                  stop_bit_q, stop_bit_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic sample_done, sample_bit, bit_end;
    logic start_det;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign start_det = (state_q == IDLE) && !rx_s_q;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .rx_s_i        (rx_s_q),
        .start_i       (start_det),
        .active_i      (state_q != IDLE),
        .prescale_i    (prescale_q),
        .sample_done_o (sample_done),
        .sample_bit_o  (sample_bit),
        .bit_end_o     (bit_end)
    );

    // Frame FSM: bit sequencing, shifting, checks and output pulse decisions.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        prescale_d = prescale_q;
        par_bad_d  = par_bad_q;
        stop_bit_d = stop_bit_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    // Configuration is frozen for the whole frame from here.
                    state_d    = START;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = PRESCALE;
                    par_bad_d  = 1'b0;
                    stop_bit_d = 1'b1;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                // A start bit that votes high at its centre was only a glitch.
                if (sample_done && sample_bit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_d = {sample_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_done) begin
                    par_bad_d = (sample_bit != par_calc(shift_q, par_typ_q));
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_done) begin
                    stop_bit_d = sample_bit;
                end
                if (bit_end) begin
                    state_d = IDLE;
                    if (stop_bit_q && !par_bad_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                    pe_d = par_bad_q;
                    se_d = !stop_bit_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= PRESCALE_W'(PRESCALE_8);
            par_bad_q  <= 1'b0;
            stop_bit_q <= 1'b1;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            prescale_q <= prescale_d;
            par_bad_q  <= par_bad_d;
            stop_bit_q <= stop_bit_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames cycle by cycle and
// compares every output pulse against a frame-level reference model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd16;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err, busy;

    uart_rx dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .PRESCALE   (prescale),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_ERR    (par_err),
        .STP_ERR    (stp_err),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frame_start_cyc = 0;
    int last_dv_cyc     = 0;

    // Event word: {DATA_VALID, PAR_ERR, STP_ERR, P_DATA}
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle on which any pulse output is high.
    always @(negedge clk) begin
        if (!rst && (data_valid || par_err || stp_err)) begin
            obs_q.push_back({data_valid, par_err, stp_err, p_data});
            if (data_valid) last_dv_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Reference model: one event per complete frame, decided from what was sent.
    task automatic expect_frame(input logic [7:0] d, input logic pen,
                                input logic bad_par, input logic sbit);
        logic perr;
        logic serr;
        perr = pen && bad_par;
        serr = !sbit;
        if (!perr && !serr) begin
            last_good = d;
            exp_q.push_back({1'b1, 1'b0, 1'b0, d});
        end else begin
            exp_q.push_back({1'b0, perr, serr, last_good});
        end
    endtask

    function automatic logic [5:0] pick_p();
        logic [5:0] base;
        base = 6'd8;
        return base << $urandom_range(0, 2);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 rx_in = 1'b1;
        end
    endtask

    // Drive one frame (or its first nsend bits) one clock at a time. With
    // flip set, the line is inverted for one clock per bit at offset P/2-1.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input int p, input logic bad_par, input logic sbit,
                              input logic flip, input int nsend);
        logic bits[$];
        logic good_pbit;
        logic b;
        good_pbit = ptyp ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(good_pbit ^ bad_par);
        bits.push_back(sbit);
        if (nsend >= bits.size()) expect_frame(d, pen, bad_par, sbit);
        par_en   = pen;
        par_typ  = ptyp;
        prescale = 6'(p);
        for (int i = 0; i < bits.size() && i < nsend; i++) begin
            for (int c = 0; c < p; c++) begin
                @(posedge clk);
                #1;
                if (i == 0 && c == 0) frame_start_cyc = cyc;
                b = bits[i];
                rx_in = (flip && c == p/2 - 1) ? ~b : b;
                // Configuration is already latched; scramble it to prove so.
                if (i == 1 && c == 0) begin
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                    prescale = pick_p();
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        idle(8);
        check($sformatf("%s_evt_count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_evt%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       pen, ptyp, bp, sb, fl;
        int         p;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_p_data", p_data, 0);
        check("rst_pulses", {data_valid, par_err, stp_err}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(4);

        // Good even-parity frame at P=8, with output latency check
        send_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, 99);
        drain("a5");
        check("a5_latency", last_dv_cyc - frame_start_cyc, 11*8 + 2);

        // Parity error at P=16 odd parity: P_DATA must keep 0xA5
        send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b1, 1'b1, 1'b0, 99);
        drain("par");

        // Stop error, line stays low straight into the next frame's start bit
        send_frame(8'h81, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 99);
        send_frame(8'h42, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 99);
        drain("stp");

        // Start glitch: 3 clocks low, abort at the P/2 vote
        par_en = 1'b0; prescale = 6'd16;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 rx_in = (i == 3);
        end
        @(negedge clk);
        check("glitch_busy_hi", busy, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_lo", busy, 0);
        drain("glitch");

        // Back-to-back frames at P=32 with a single stop bit each
        send_frame(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0, 99);
        send_frame(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0, 99);
        send_frame(8'h55, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0, 99);
        drain("b2b");

        // One disturbed sample per bit must be voted out
        send_frame(8'h5A, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b1, 99);
        drain("jitter");

        // Reset in the middle of the data bits
        send_frame(8'hC3, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 4);
        @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_p_data", p_data, 0);
        check("mid_rst_pulses", {data_valid, par_err, stp_err}, 0);
        check("mid_rst_busy", busy, 0);
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        idle(3);
        send_frame(8'h99, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 99);
        drain("after_rst");

        // Randomised batches of frames with random gaps, errors and jitter
        for (int b = 0; b < 5; b++) begin
            for (int f = 0; f < 5; f++) begin
                d    = 8'($urandom);
                pen  = 1'($urandom);
                ptyp = 1'($urandom);
                p    = int'(pick_p());
                bp   = ($urandom_range(0, 5) == 0);
                sb   = ($urandom_range(0, 7) != 0);
                fl   = ($urandom_range(0, 2) == 0);
                send_frame(d, pen, ptyp, p, bp, sb, fl, 99);
                idle($urandom_range(0, 2));
            end
            drain($sformatf("rnd%0d", b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
